// File: rtl/mux_recirc_src_ctrl.sv
// mux_recirc_src_ctrl: c1-side launch controller holding A/EN stable until the c2 toggle ack returns
module mux_recirc_src_ctrl #(
  parameter int W           = 2,
  parameter int EN_CYCLES   = 3,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 64
) (
  input  logic         c1,
  input  logic         rstn,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic [W-1:0] A,
  output logic         EN,
  input  logic         ack_tgl,
  input  logic         err_clr,
  output logic         busy,
  output logic         timeout_err,
  output logic [15:0]  tx_count
);
  localparam int HW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [3:0] EN_LAST = 4'(EN_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, LAUNCH, HOLD} state_t;
  state_t state;
  logic [SYNC_STAGES-1:0] sync;
  logic hist, ack_seen, ack_evt;
  logic [3:0] en_cnt;
  logic [HW-1:0] hold_cnt;
  assign ack_evt  = sync[SYNC_STAGES-1] ^ hist;
  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  always_ff @(posedge c1 or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      A           <= '0;
      EN          <= 1'b0;
      timeout_err <= 1'b0;
      tx_count    <= '0;
      sync        <= '0;
      hist        <= 1'b0;
      ack_seen    <= 1'b0;
      en_cnt      <= '0;
      hold_cnt    <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], ack_tgl};
      hist <= sync[SYNC_STAGES-1];
      if (err_clr) timeout_err <= 1'b0;
      case (state)
        IDLE: if (in_valid) begin
          A        <= in_data;
          EN       <= 1'b1;
          en_cnt   <= '0;
          ack_seen <= 1'b0;
          state    <= LAUNCH;
        end
        LAUNCH: begin
          en_cnt <= en_cnt + 4'd1;
          if (en_cnt == EN_LAST) begin
            EN <= 1'b0;
            if (ack_seen || ack_evt) begin
              state    <= IDLE;
              tx_count <= tx_count + 16'd1;
            end else begin
              state    <= HOLD;
              hold_cnt <= '0;
            end
          end else if (ack_evt) ack_seen <= 1'b1;
        end
        HOLD: if (ack_evt) begin
          state    <= IDLE;
          tx_count <= tx_count + 16'd1;
        end else if (TIMEOUT != 0 && hold_cnt == HOLD_LAST) begin
          state       <= IDLE;
          timeout_err <= 1'b1;
        end else hold_cnt <= hold_cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mux_recirc_src_ctrl.sv
// tb_mux_recirc_src_ctrl: directed bench with a behavioural c2-side recirculation sync in the loop
module tb_mux_recirc_src_ctrl;
  logic c1, c2, rstn, in_valid, tb_ack, err_clr, use_model, model_ack;
  logic [1:0] in_data, A;
  logic in_ready, EN, busy, timeout_err;
  logic [15:0] tx_count;
  logic [1:0] en_s;
  logic en_d;
  logic [1:0] got [0:15];
  int n_got;
  int checks = 0, failures = 0;
  mux_recirc_src_ctrl #(.W(2), .EN_CYCLES(3), .SYNC_STAGES(2), .TIMEOUT(8)) dut (
    .c1(c1), .rstn(rstn), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .A(A), .EN(EN), .ack_tgl(use_model ? model_ack : tb_ack), .err_clr(err_clr),
    .busy(busy), .timeout_err(timeout_err), .tx_count(tx_count));
  initial begin c1 = 0; forever #5 c1 = ~c1; end
  initial begin c2 = 0; #2; forever begin c2 = 1; #7; c2 = 0; #7; end end
  always @(posedge c2 or negedge rstn) begin
    if (!rstn) begin
      en_s <= 0; en_d <= 0; model_ack <= 0; n_got <= 0;
    end else if (use_model) begin
      en_s <= {en_s[0], EN};
      en_d <= en_s[1];
      if (en_s[1] && !en_d) begin
        got[n_got[3:0]] <= A;
        n_got <= n_got + 1;
        model_ack <= ~model_ack;
      end
    end
  end
  task automatic step(int n = 1);
    repeat (n) @(posedge c1);
    #1;
  endtask
  task automatic test_reset;
    rstn = 0; in_valid = 0; in_data = 0; tb_ack = 0; err_clr = 0; use_model = 0;
    step(2);
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL reset_ready in_ready=%b busy=%b exp 1 0", in_ready, busy); end
    checks++; if (EN !== 1'b0 || A !== 2'd0) begin failures++; $display("FAIL reset_out EN=%b A=%0d exp 0 0", EN, A); end
    checks++; if (tx_count !== 16'd0 || timeout_err !== 1'b0) begin failures++; $display("FAIL reset_cnt tx=%0d err=%b exp 0 0", tx_count, timeout_err); end
    rstn = 1;
    step();
  endtask
  task automatic test_launch;
    in_valid = 1; in_data = 2'b10;
    step();
    in_valid = 0; in_data = 2'b01;
    checks++; if (A !== 2'd2 || EN !== 1'b1 || in_ready !== 1'b0) begin failures++; $display("FAIL launch_accept A=%0d EN=%b rdy=%b exp 2 1 0", A, EN, in_ready); end
    step();
    checks++; if (EN !== 1'b1) begin failures++; $display("FAIL launch_en2 EN=%b exp 1", EN); end
    step();
    checks++; if (EN !== 1'b1) begin failures++; $display("FAIL launch_en3 EN=%b exp 1", EN); end
    step();
    checks++; if (EN !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b0) begin failures++; $display("FAIL launch_hold EN=%b busy=%b rdy=%b exp 0 1 0", EN, busy, in_ready); end
  endtask
  task automatic test_hold_ack;
    tb_ack = 1;
    step(2);
    checks++; if (busy !== 1'b1 || tx_count !== 16'd0) begin failures++; $display("FAIL hold_wait busy=%b tx=%0d exp 1 0", busy, tx_count); end
    step();
    checks++; if (in_ready !== 1'b1 || tx_count !== 16'd1 || A !== 2'd2) begin failures++; $display("FAIL hold_ack rdy=%b tx=%0d A=%0d exp 1 1 2", in_ready, tx_count, A); end
    step(2);
    checks++; if (in_ready !== 1'b1 || tx_count !== 16'd1) begin failures++; $display("FAIL idle_stable rdy=%b tx=%0d exp 1 1", in_ready, tx_count); end
  endtask
  task automatic test_launch_ack;
    in_valid = 1; in_data = 2'd1; tb_ack = 0;
    step();
    in_valid = 0;
    step(2);
    checks++; if (EN !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL early_ack_mid EN=%b busy=%b exp 1 1", EN, busy); end
    step();
    checks++; if (EN !== 1'b0 || in_ready !== 1'b1 || tx_count !== 16'd2 || A !== 2'd1) begin failures++; $display("FAIL early_ack_seen EN=%b rdy=%b tx=%0d A=%0d exp 0 1 2 1", EN, in_ready, tx_count, A); end
    in_valid = 1; in_data = 2'd3;
    step();
    in_valid = 0; tb_ack = 1;
    step(3);
    checks++; if (EN !== 1'b0 || in_ready !== 1'b1 || tx_count !== 16'd3 || A !== 2'd3) begin failures++; $display("FAIL late_ack_evt EN=%b rdy=%b tx=%0d A=%0d exp 0 1 3 3", EN, in_ready, tx_count, A); end
  endtask
  task automatic test_timeout;
    in_valid = 1; in_data = 2'd0;
    step();
    in_valid = 0;
    step(10);
    checks++; if (busy !== 1'b1 || timeout_err !== 1'b0) begin failures++; $display("FAIL timeout_early busy=%b err=%b exp 1 0", busy, timeout_err); end
    step();
    checks++; if (in_ready !== 1'b1 || timeout_err !== 1'b1 || tx_count !== 16'd3) begin failures++; $display("FAIL timeout_hit rdy=%b err=%b tx=%0d exp 1 1 3", in_ready, timeout_err, tx_count); end
    step();
    checks++; if (timeout_err !== 1'b1) begin failures++; $display("FAIL timeout_sticky err=%b exp 1", timeout_err); end
    err_clr = 1;
    step();
    err_clr = 0;
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL err_clr err=%b exp 0", timeout_err); end
  endtask
  task automatic test_reset_mid;
    in_valid = 1; in_data = 2'd3;
    step();
    in_valid = 0;
    step();
    rstn = 0; tb_ack = 0;
    #1;
    checks++; if (EN !== 1'b0 || A !== 2'd0 || busy !== 1'b0 || tx_count !== 16'd0) begin failures++; $display("FAIL reset_mid EN=%b A=%0d busy=%b tx=%0d exp 0 0 0 0", EN, A, busy, tx_count); end
    step();
    rstn = 1;
    step();
  endtask
  task automatic test_back_to_back;
    logic [1:0] words [0:9];
    int wait_cyc;
    words = '{2'd2, 2'd1, 2'd3, 2'd0, 2'd3, 2'd3, 2'd1, 2'd0, 2'd2, 2'd1};
    use_model = 1; in_valid = 1;
    for (int i = 0; i < 10; i++) begin
      in_data = words[i];
      wait_cyc = 0;
      while (!in_ready && wait_cyc < 200) begin step(); wait_cyc++; end
      step();
    end
    in_valid = 0;
    wait_cyc = 0;
    while (!(in_ready && tx_count == 16'd10) && wait_cyc < 400) begin step(); wait_cyc++; end
    step(4);
    checks++; if (tx_count !== 16'd10 || n_got != 10) begin failures++; $display("FAIL b2b_count tx=%0d got=%0d exp 10 10", tx_count, n_got); end
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL b2b_no_timeout err=%b exp 0", timeout_err); end
    for (int i = 0; i < 10; i++) begin
      checks++; if (got[i] !== words[i]) begin failures++; $display("FAIL b2b_word%0d B=%0d exp %0d", i, got[i], words[i]); end
    end
  endtask
  initial begin
    test_reset;
    test_launch;
    test_hold_ack;
    test_launch_ack;
    test_timeout;
    test_reset_mid;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
